// File: rtl/l15_mem_responder.sv
// rtl/l15_mem_responder.sv - L1.5 memory-side responder: in-order request queue, backing memory, typed returns
module l15_mem_responder #(
  parameter int TidWidth  = 2,
  parameter int AddrWidth = 40,
  parameter int MemWords  = 256,
  parameter int FifoDepth = 4,
  parameter int Latency   = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_val_i,
  input  logic [4:0]           req_rqtype_i,
  input  logic [2:0]           req_size_i,
  input  logic [TidWidth-1:0]  req_threadid_i,
  input  logic [AddrWidth-1:0] req_address_i,
  input  logic [63:0]          req_data_i,
  output logic                 req_header_ack_o,
  output logic                 rtn_val_o,
  input  logic                 rtn_ack_i,
  output logic [3:0]           rtn_type_o,
  output logic [TidWidth-1:0]  rtn_threadid_o,
  output logic [127:0]         rtn_data_o
);

  localparam int IdxW = $clog2(MemWords);
  localparam int PtrW = $clog2(FifoDepth);
  localparam logic [3:0]  CdInit  = 4'(Latency - 1);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(FifoDepth);

  typedef enum logic [1:0] {K_LOAD, K_IFILL, K_STORE, K_ERR} kind_e;

  kind_e               q_kind [FifoDepth];
  logic [7:0]          q_be   [FifoDepth];
  logic [IdxW-1:0]     q_idx  [FifoDepth];
  logic [TidWidth-1:0] q_tid  [FifoDepth];
  logic [63:0]         q_data [FifoDepth];
  logic [3:0]          q_cd   [FifoDepth];
  logic [PtrW-1:0]     wr_ptr, rd_ptr;
  logic [PtrW:0]       count;
  logic [63:0]         mem [MemWords];

  kind_e           in_kind;
  logic [7:0]      in_be;
  logic [2:0]      size_mask;
  logic [2:0]      off;
  logic [IdxW-1:0] in_idx;
  logic            push, pop;
  logic            unused_addr_hi;

  assign off            = req_address_i[2:0];
  assign in_idx         = req_address_i[IdxW+2:3];
  assign unused_addr_hi = ^req_address_i[AddrWidth-1:IdxW+3];

  // Legality and misalignment are resolved at accept, so the head only needs a kind and byte enables
  always_comb begin
    in_kind   = K_ERR;
    in_be     = '0;
    size_mask = 3'd0;
    case (req_rqtype_i)
      5'd0:    in_kind = K_LOAD;
      5'd1:    in_kind = K_STORE;
      5'd16:   in_kind = K_IFILL;
      default: in_kind = K_ERR;
    endcase
    case (req_size_i)
      3'd0:    size_mask = 3'b000;
      3'd1:    size_mask = 3'b001;
      3'd2:    size_mask = 3'b011;
      3'd3:    size_mask = 3'b111;
      default: in_kind   = K_ERR;
    endcase
    if (in_kind == K_STORE && (off & size_mask) != 3'd0) in_kind = K_ERR;
    if (in_kind == K_STORE) begin
      for (int k = 0; k < 8; k++) in_be[k] = ((3'(k) & ~size_mask) == off);
    end
  end

  logic            h_val;
  kind_e           h_kind;
  logic [IdxW-1:0] h_idx, line_lo, line_hi;

  assign h_kind  = q_kind[rd_ptr];
  assign h_idx   = q_idx[rd_ptr];
  assign line_lo = {h_idx[IdxW-1:1], 1'b0};
  assign line_hi = {h_idx[IdxW-1:1], 1'b1};
  assign h_val   = (count != '0) && (q_cd[rd_ptr] == 4'd0);

  assign req_header_ack_o = req_val_i && !rst_i && (count < FullCnt);
  assign rtn_val_o        = h_val;
  assign push             = req_header_ack_o;
  assign pop              = h_val && rtn_ack_i;

  always_comb begin
    rtn_type_o     = 4'd0;
    rtn_threadid_o = '0;
    rtn_data_o     = '0;
    if (h_val) begin
      rtn_threadid_o = q_tid[rd_ptr];
      case (h_kind)
        K_LOAD:  begin rtn_type_o = 4'd0; rtn_data_o = {mem[line_lo], mem[line_hi]}; end
        K_IFILL: begin rtn_type_o = 4'd1; rtn_data_o = {mem[line_lo], mem[line_hi]}; end
        K_STORE: rtn_type_o = 4'd4;
        default: rtn_type_o = 4'd15;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FifoDepth; i++) begin
        q_kind[i] <= K_LOAD;
        q_be[i]   <= '0;
        q_idx[i]  <= '0;
        q_tid[i]  <= '0;
        q_data[i] <= '0;
        q_cd[i]   <= '0;
      end
      for (int w = 0; w < MemWords; w++) mem[w] <= '0;
    end else begin
      for (int i = 0; i < FifoDepth; i++) begin
        if (q_cd[i] != 4'd0) q_cd[i] <= q_cd[i] - 4'd1;
      end
      if (push) begin
        q_kind[wr_ptr] <= in_kind;
        q_be[wr_ptr]   <= in_be;
        q_idx[wr_ptr]  <= in_idx;
        q_tid[wr_ptr]  <= req_threadid_i;
        q_data[wr_ptr] <= req_data_i;
        q_cd[wr_ptr]   <= CdInit;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      // Stores land only when their response transfers, keeping memory in program order
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (h_kind == K_STORE) begin
          for (int k = 0; k < 8; k++) begin
            if (q_be[rd_ptr][k]) mem[h_idx][63-8*k -: 8] <= q_data[rd_ptr][63-8*k -: 8];
          end
        end
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_l15_mem_responder.sv
// tb/tb_l15_mem_responder.sv - directed bench with reference model and response scoreboard
module tb_l15_mem_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_val;
  logic [4:0]   req_rqtype;
  logic [2:0]   req_size;
  logic [1:0]   req_tid;
  logic [39:0]  req_addr;
  logic [63:0]  req_data;
  logic         req_ack;
  logic         rtn_val;
  logic         rtn_ack;
  logic [3:0]   rtn_type;
  logic [1:0]   rtn_tid;
  logic [127:0] rtn_data;

  int checks   = 0;
  int failures = 0;
  logic [133:0] sb[$];
  logic [63:0]  mm [256];

  always #5 clk = ~clk;

  l15_mem_responder #(
    .TidWidth(2), .AddrWidth(40), .MemWords(256), .FifoDepth(4), .Latency(3)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_val_i(req_val), .req_rqtype_i(req_rqtype), .req_size_i(req_size),
    .req_threadid_i(req_tid), .req_address_i(req_addr), .req_data_i(req_data),
    .req_header_ack_o(req_ack),
    .rtn_val_o(rtn_val), .rtn_ack_i(rtn_ack), .rtn_type_o(rtn_type),
    .rtn_threadid_o(rtn_tid), .rtn_data_o(rtn_data)
  );

  task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: applies stores in issue order and returns {type, tid, data}
  function automatic logic [133:0] model(input logic [4:0] rq, input logic [2:0] sz,
                                         input logic [1:0] tid, input logic [39:0] a,
                                         input logic [63:0] d);
    int w, l, o, nb;
    w = int'(a[10:3]);
    l = w - (w % 2);
    o = int'(a[2:0]);
    if (!(rq == 5'd0 || rq == 5'd1 || rq == 5'd16) || sz > 3'd3) return {4'd15, tid, 128'd0};
    if (rq == 5'd1) begin
      nb = 1 << sz;
      if (o % nb != 0) return {4'd15, tid, 128'd0};
      for (int k = o; k < o + nb; k++) mm[w][63-8*k -: 8] = d[63-8*k -: 8];
      return {4'd4, tid, 128'd0};
    end
    return {(rq == 5'd16) ? 4'd1 : 4'd0, tid, mm[l], mm[l+1]};
  endfunction

  always @(negedge clk) begin
    if (!rst && rtn_val && rtn_ack) begin
      if (sb.size() == 0) check("rtn_unexpected", 134'(sb.size()), 134'(1));
      else check("rtn", {rtn_type, rtn_tid, rtn_data}, sb.pop_front());
    end
  end

  task automatic set_req(input logic [4:0] rq, input logic [2:0] sz, input logic [1:0] tid,
                         input logic [39:0] a, input logic [63:0] d);
    req_val = 1'b1; req_rqtype = rq; req_size = sz; req_tid = tid; req_addr = a; req_data = d;
  endtask

  task automatic send(input logic [4:0] rq, input logic [2:0] sz, input logic [1:0] tid,
                      input logic [39:0] a, input logic [63:0] d,
                      input bit use_exp, input logic [127:0] exp_data);
    logic [133:0] e;
    bit got = 1'b0;
    set_req(rq, sz, tid, a, d);
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ack) got = 1'b1;
    end
    if (got) begin
      e = model(rq, sz, tid, a, d);
      if (use_exp) e[127:0] = exp_data;
      sb.push_back(e);
    end else check("send_ack_timeout", 134'(got), 134'(1));
    @(posedge clk); #1;
    req_val = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 134'(sb.size()), 134'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [133:0] snap;
    int acks;
    rst = 1'b1; rtn_ack = 1'b0;
    req_val = 1'b0; req_rqtype = '0; req_size = '0; req_tid = '0; req_addr = '0; req_data = '0;
    for (int w = 0; w < 256; w++) mm[w] = '0;
    repeat (2) @(negedge clk);
    check("reset_rtn", {rtn_type, rtn_tid, rtn_data}, 134'(0));
    check("reset_val", 134'({req_ack, rtn_val}), 134'(0));
    req_val = 1'b1; #1;
    check("reset_ack_forced", 134'(req_ack), 134'(0));
    req_val = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Store then load of the same line
    rtn_ack = 1'b1;
    send(5'd1, 3'd3, 2'd1, 40'h8, 64'h0011223344556677, 1'b0, '0);
    send(5'd0, 3'd3, 2'd2, 40'h0, 64'h0, 1'b1, {64'h0, 64'h0011223344556677});
    wait_drain();

    // Sub-word big-endian stores
    send(5'd1, 3'd0, 2'd0, 40'h13, 64'hABABABABABABABAB, 1'b0, '0);
    send(5'd0, 3'd3, 2'd1, 40'h10, 64'h0, 1'b1, {64'h000000AB00000000, 64'h0});
    send(5'd1, 3'd1, 2'd2, 40'h16, 64'hCDCDCDCDCDCDCDCD, 1'b0, '0);
    send(5'd0, 3'd3, 2'd3, 40'h10, 64'h0, 1'b1, {64'h000000AB0000CDCD, 64'h0});
    wait_drain();

    // Latency and hold-stable
    rtn_ack = 1'b0;
    send(5'd16, 3'd3, 2'd1, 40'h8, 64'h0, 1'b0, '0);
    @(negedge clk); check("lat_cycle1", 134'(rtn_val), 134'(0));
    @(negedge clk); check("lat_cycle2", 134'(rtn_val), 134'(0));
    @(negedge clk); check("lat_cycle3", 134'(rtn_val), 134'(1));
    snap = {rtn_type, rtn_tid, rtn_data};
    repeat (4) begin
      @(negedge clk);
      check("hold_stable", {rtn_type, rtn_tid, rtn_data}, snap);
      check("hold_val", 134'(rtn_val), 134'(1));
    end
    @(posedge clk); #1; rtn_ack = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); check("after_pop_val", 134'(rtn_val), 134'(0));
    @(posedge clk); #1;

    // Full queue backpressure
    rtn_ack = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      set_req(5'd0, 3'd3, 2'(i), 40'(i * 8), 64'h0);
      @(negedge clk);
      check("fill_ack", 134'(req_ack), 134'(1));
      if (req_ack) begin acks++; sb.push_back(model(5'd0, 3'd3, 2'(i), 40'(i * 8), 64'h0)); end
      @(posedge clk); #1;
    end
    set_req(5'd0, 3'd3, 2'd0, 40'h20, 64'h0);
    repeat (3) begin
      @(negedge clk);
      check("full_ack_low", 134'(req_ack), 134'(0));
      if (req_ack) acks++;
    end
    check("acks_while_full", 134'(acks), 134'(4));
    @(posedge clk); #1; rtn_ack = 1'b1;
    @(negedge clk);
    check("xfer_cycle_ack_low", 134'(req_ack), 134'(0));
    check("xfer_cycle_val", 134'(rtn_val), 134'(1));
    @(posedge clk); #1;
    @(negedge clk);
    check("ack_returns", 134'(req_ack), 134'(1));
    if (req_ack) sb.push_back(model(5'd0, 3'd3, 2'd0, 40'h20, 64'h0));
    @(posedge clk); #1;
    set_req(5'd0, 3'd3, 2'd1, 40'h28, 64'h0);
    @(negedge clk);
    check("sixth_ack", 134'(req_ack), 134'(1));
    if (req_ack) sb.push_back(model(5'd0, 3'd3, 2'd1, 40'h28, 64'h0));
    @(posedge clk); #1; req_val = 1'b0;
    wait_drain();

    // Illegal type and misaligned store
    send(5'd7, 3'd3, 2'd3, 40'h0, 64'h0, 1'b0, '0);
    send(5'd1, 3'd2, 2'd0, 40'h2, 64'hFFFFFFFFFFFFFFFF, 1'b0, '0);
    send(5'd1, 3'd5, 2'd2, 40'h0, 64'hFFFFFFFFFFFFFFFF, 1'b0, '0);
    send(5'd0, 3'd3, 2'd1, 40'h0, 64'h0, 1'b1, {64'h0, 64'h0011223344556677});
    wait_drain();

    // Reset mid-operation
    rtn_ack = 1'b0;
    send(5'd1, 3'd3, 2'd1, 40'h30, 64'h1111111111111111, 1'b0, '0);
    send(5'd1, 3'd3, 2'd2, 40'h38, 64'h2222222222222222, 1'b0, '0);
    send(5'd1, 3'd3, 2'd3, 40'h8, 64'h3333333333333333, 1'b0, '0);
    for (int i = 0; i < 20 && !rtn_val; i++) @(negedge clk);
    check("rst_pre_val", 134'(rtn_val), 134'(1));
    @(posedge clk); #2;
    rst = 1'b1; #1;
    check("rst_async_val", 134'(rtn_val), 134'(0));
    check("rst_async_rtn", {rtn_type, rtn_tid, rtn_data}, 134'(0));
    sb.delete();
    for (int w = 0; w < 256; w++) mm[w] = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; rtn_ack = 1'b1;
    send(5'd0, 3'd3, 2'd0, 40'h8, 64'h0, 1'b1, 128'd0);
    send(5'd0, 3'd3, 2'd1, 40'h30, 64'h0, 1'b1, 128'd0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l15_mem_responder.md
Name: l15_mem_responder

Overview:
- Memory-side responder for the L1.5 (OpenPiton big-endian NoC) request/return interface driven by the write-through cache subsystem.
- Accepts load, store and instruction-fill requests and queues them in order.
- Applies them to a small internal backing memory and returns typed responses with the originating thread ID after a programmable minimum latency.
- Serves as the bench-side model that closes the core's L1.5 port in standalone and unit simulation.

Parameters:
- TidWidth, 2, width of req/rtn thread ID (matches memory TID width).
- AddrWidth, 40, request physical address width.
- MemWords, 256, number of 64-bit backing words; power of 2, ≥2.
- FifoDepth, 4, request queue entries; power of 2, ≥2.
- Latency, 3, minimum cycles from request acceptance to rtn_val; range 1..15.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_val_i  in  1  request valid.
- req_rqtype_i  in  5  request type: 0 LOAD, 1 STORE, 16 IMISS; others illegal.
- req_size_i  in  3  0=1B, 1=2B, 2=4B, 3=8B; others illegal.
- req_threadid_i  in  TidWidth  request tag.
- req_address_i  in  AddrWidth  byte address.
- req_data_i  in  64  store data, big-endian, replicated per size.
- req_header_ack_o  out  1  request accepted this cycle.
- rtn_val_o  out  1  response valid.
- rtn_ack_i  in  1  response consumed.
- rtn_type_o  out  4  0 LOAD_RET, 1 IFILL_RET, 4 ST_ACK, 15 ERR.
- rtn_threadid_o  out  TidWidth  echo of request tag.
- rtn_data_o  out  128  line data; [127:64] = lower-address word.

Behaviour:
- Reset (async, rst_i=1):
  - FIFO emptied; all entry counters cleared.
  - Backing memory cleared to 0.
  - Outputs forced: req_header_ack_o=0, rtn_val_o=0, rtn_type_o=0, rtn_threadid_o=0, rtn_data_o=0.
  - Reset asserted mid-operation discards queued and pending responses immediately; no partial store is applied.
- Accept:
  - req_header_ack_o = req_val_i && (count < FifoDepth), combinational.
  - Accepted request stored at tail with countdown = Latency-1.
  - No fall-through when full: a pop in the same cycle does not free a slot until the next cycle.
- Countdown: every valid entry decrements by 1 each cycle, saturating at 0.
- Respond:
  - rtn_val_o = !empty && head.countdown==0.
  - Head outputs stay stable while rtn_val_o && !rtn_ack_i.
  - Transfer occurs on rtn_val_o && rtn_ack_i; head pops the same cycle.
  - Back-to-back transfers are allowed when the next entry's countdown is already 0.
- Ordering:
  - Strictly in order.
  - Memory effects (store writes) and load reads both occur at head transfer time, so program order is preserved.
  - A load queued behind a store observes that store.
- Indexing:
  - word index = address[$clog2(MemWords)+2:3], modulo MemWords.
  - Higher address bits are ignored (aliasing).
  - Line index clears address bit 3.
- LOAD / IMISS:
  - rtn_data_o = {mem[line], mem[line|1]} (word at lower address in the high half).
  - Type is LOAD_RET or IFILL_RET respectively.
  - Size is ignored for the read.
- STORE:
  - Byte offset o = address[2:0]; size bytes starting at o are written.
  - Byte at offset k maps to word bits [63-8k -: 8] of req_data_i (big-endian).
  - Response type is ST_ACK; rtn_data_o = 0.
  - A misaligned store (o not a multiple of the size) is not written and returns ERR.
- Illegal rqtype or size: no memory effect; returns ERR with the tag echoed and rtn_data_o = 0.
- Simultaneous accept and pop: count unchanged, both take effect.

Test Plan:
- Reset, store 8B 0x0011223344556677 @0x8 tid1, then load @0x0 tid2 -> ST_ACK tid1, then LOAD_RET tid2 data {0, 0x0011223344556677}.
- Store 1B data 0xABABABABABABABAB @0x13 onto a zeroed word -> mem[2]=0x000000AB00000000. Follow with a 2B store of 0xCDCD… @0x16 -> mem[2]=0x000000AB0000CDCD.
- Latency=3, single request at cycle 0 -> rtn_val_o first high at cycle 3. With rtn_ack_i held 0 for 5 cycles, outputs stay stable; transfer occurs on the ack cycle.
- Issue 6 requests back-to-back with rtn_ack_i=0 -> exactly 4 acks. Ack is low while full and returns 1 cycle after the first transfer; the order of tags is preserved.
- rqtype=7 tid3, then a misaligned 4B store @0x2 -> ERR tid3, then ERR; memory unchanged.
- Assert rst_i with 3 entries queued and rtn_val_o=1 -> rtn_val_o drops asynchronously. After release, a load @0x8 returns 0 and no queued store has been applied.
